fc_layer: RTL

- Fully-connected (dense) layer engine: the stage downstream of the final max-pool stage in the LeNet layer sequence.
- Started by the top-level sequencer, exactly like the conv/relu/pool engines, and shares the single-port DRAM interface muxed by the sequencer.
- Reads the pooled feature vector, weights and biases from DRAM; computes out[o] = sat(bias[o] + sum_i in[i]*w[o][i]) in signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS fixed point; writes results back to DRAM.
- Pulses done when the last write has issued.

---
 rtl/fc_layer_if.sv | 31 +++
 rtl/fc_layer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_if.sv
// DRAM bus between the fc_layer engine and the sequencer's shared single-port DRAM mux.
//   dram_valid  : data_in holds the word requested on addr_in
//   data_in     : DRAM read data
//   data_out    : DRAM write data
//   addr_in     : DRAM read address
//   addr_out    : DRAM write address
//   dram_en_wr  : one-cycle write strobe
//   dram_en_rd  : read request, held until dram_valid
// The engine side uses modport master; the DRAM/mux side uses modport slave.
interface fc_layer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18
) ();
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  dram_en_wr;
    logic                  dram_en_rd;

    modport master (
        input  dram_valid, data_in,
        output data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
    );

    modport slave (
        output dram_valid, data_in,
        input  data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
    );
endinterface

// File: rtl/fc_layer.sv
// Fully-connected layer engine. Computes, for each output neuron o,
//   out[o] = sat((bias[o] << FRAC_BITS + sum_i in[i]*w[o][i]) >>> FRAC_BITS)
// in signed fixed point, fetching every operand from DRAM one word at a time and writing each
// result back as soon as its accumulation finishes.
// Ports:
//   clk    : clock
//   srstn  : synchronous active-low reset
//   enable : start request, sampled only while idle (must drop before a restart is accepted)
//   done   : one-cycle pulse after the last output write
//   dram   : DRAM bus (reads with valid handshake, single-cycle writes); all outputs registered
module fc_layer #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 18,
    parameter int unsigned           FRAC_BITS  = 16,
    parameter int unsigned           NUM_IN     = 400,
    parameter int unsigned           NUM_OUT    = 120,
    parameter logic [ADDR_WIDTH-1:0] IN_BASE    = 18'h00000,
    parameter logic [ADDR_WIDTH-1:0] WGT_BASE   = 18'h01000,
    parameter logic [ADDR_WIDTH-1:0] BIAS_BASE  = 18'h20000,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = 18'h30000
) (
    input  logic       clk,
    input  logic       srstn,
    input  logic       enable,
    output logic       done,
    fc_layer_if.master dram
);
    localparam int unsigned CNT_W = 12;
    localparam int unsigned ACC_W = 2 * DATA_WIDTH + 12;

    typedef enum logic [2:0] {StIdle, StRdBias, StRdIn, StRdWgt, StMac, StWr, StFin} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      o_q, o_d, i_q, i_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DATA_WIDTH-1:0] x_q, x_d, w_q, w_d;
    logic                  armed_q, armed_d;
    logic                  rd_q, rd_d, wr_q, wr_d, done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_in_q, addr_in_d, addr_out_q, addr_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc_shift;
    logic [ACC_W-DATA_WIDTH:0]      sign_ext;
    logic [DATA_WIDTH-1:0]          sat_val;

    assign prod = $signed(x_q) * $signed(w_q);

    always_comb begin
        state_d    = state_q;
        o_d        = o_q;
        i_d        = i_q;
        acc_d      = acc_q;
        x_d        = x_q;
        w_d        = w_q;
        armed_d    = armed_q;
        addr_in_d  = addr_in_q;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;

        case (state_q)
            StIdle: begin
                if (enable && armed_q) begin
                    state_d = StRdBias;
                    o_d     = '0;
                    armed_d = 1'b0;
                end else if (!enable) begin
                    armed_d = 1'b1;
                end
            end
            StRdBias: begin
                if (dram.dram_valid) begin
                    // Bias moves into the product scale (2*FRAC_BITS fractional bits).
                    acc_d   = {{(ACC_W-DATA_WIDTH){dram.data_in[DATA_WIDTH-1]}}, dram.data_in}
                              << FRAC_BITS;
                    i_d     = '0;
                    state_d = StRdIn;
                end
            end
            StRdIn: begin
                if (dram.dram_valid) begin
                    x_d     = dram.data_in;
                    state_d = StRdWgt;
                end
            end
            StRdWgt: begin
                if (dram.dram_valid) begin
                    w_d     = dram.data_in;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + {{12{prod[2*DATA_WIDTH-1]}}, prod};
                if (i_q == CNT_W'(NUM_IN - 1)) begin
                    state_d = StWr;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = StRdIn;
                end
            end
            StWr: begin
                if (o_q == CNT_W'(NUM_OUT - 1)) begin
                    state_d = StFin;
                end else begin
                    o_d     = o_q + 1'b1;
                    state_d = StRdBias;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Saturate the floor-shifted accumulator: in range iff all bits above the data MSB
        // match the sign.
        acc_shift = $signed(acc_d) >>> FRAC_BITS;
        sign_ext  = acc_shift[ACC_W-1:DATA_WIDTH-1];
        if (&sign_ext || ~|sign_ext) begin
            sat_val = acc_shift[DATA_WIDTH-1:0];
        end else if (acc_shift[ACC_W-1]) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end

        // Outputs are registered, so they are decoded from the state being entered.
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        done_d = (state_d == StFin);
        case (state_d)
            StRdBias: begin
                rd_d      = 1'b1;
                addr_in_d = BIAS_BASE + ADDR_WIDTH'(o_d);
            end
            StRdIn: begin
                rd_d      = 1'b1;
                addr_in_d = IN_BASE + ADDR_WIDTH'(i_d);
            end
            StRdWgt: begin
                rd_d      = 1'b1;
                addr_in_d = WGT_BASE + ADDR_WIDTH'(32'(o_d) * NUM_IN) + ADDR_WIDTH'(i_d);
            end
            StWr: begin
                wr_d       = 1'b1;
                addr_out_d = OUT_BASE + ADDR_WIDTH'(o_d);
                data_out_d = sat_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q    <= StIdle;
            o_q        <= '0;
            i_q        <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            armed_q    <= 1'b1;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            addr_in_q  <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            o_q        <= o_d;
            i_q        <= i_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            w_q        <= w_d;
            armed_q    <= armed_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            addr_in_q  <= addr_in_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign dram.dram_en_rd = rd_q;
    assign dram.dram_en_wr = wr_q;
    assign dram.addr_in    = addr_in_q;
    assign dram.addr_out   = addr_out_q;
    assign dram.data_out   = data_out_q;
    assign done            = done_q;
endmodule
